// File: rtl/oclib_credit_tx.sv
// Credit-flow link transmitter: forwards local valid/ready words as
// valid-only beats while credits for the remote FIFO are held.
module oclib_credit_tx #(
  parameter int Width      = 32,
  parameter int Credits    = 32,
  parameter int CreditInW  = 2,
  parameter int LowCredits = 4,
  parameter int InitDelay  = 4,
  localparam int CntW      = $clog2(Credits + 1)
) (
  input  logic                 clock,
  input  logic                 resetN,
  input  logic [Width-1:0]     inData,
  input  logic                 inValid,
  output logic                 inReady,
  output logic [Width-1:0]     outData,
  output logic                 outValid,
  input  logic [CreditInW-1:0] creditIn,
  output logic [CntW-1:0]      creditCount,
  output logic                 lowCredits,
  output logic                 creditError
);

  localparam int SumW = (CntW > CreditInW ? CntW : CreditInW) + 1;
  localparam int TmrW = $clog2(InitDelay + 1);

  typedef enum logic {
    Init,
    Run
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [TmrW-1:0] timer_q;
  logic [TmrW-1:0] timer_d;
  logic [CntW-1:0] cnt_d;
  logic            err_d;
  logic            low_d;
  logic            send;
  logic [SumW-1:0] sum;

  assign inReady = (state_q == Run) && (creditCount != '0);
  assign send    = inValid && inReady;

  // send only happens with creditCount!=0, so the sum cannot underflow
  assign sum = SumW'(creditCount) + SumW'(creditIn) - SumW'(send);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = creditCount;
    err_d   = creditError;
    unique case (state_q)
      Init: begin
        timer_d = timer_q + 1'b1;
        if (creditIn != '0) err_d = 1'b1;
        if (timer_q == TmrW'(InitDelay - 1)) begin
          state_d = Run;
          cnt_d   = CntW'(Credits);
        end
      end
      Run: begin
        if (sum > SumW'(Credits)) begin
          cnt_d = CntW'(Credits);
          err_d = 1'b1;
        end else begin
          cnt_d = sum[CntW-1:0];
        end
      end
      default: ;
    endcase
  end

  assign low_d = 32'(cnt_d) <= 32'(LowCredits);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q     <= Init;
      timer_q     <= '0;
      creditCount <= '0;
      lowCredits  <= 1'b1;
      creditError <= 1'b0;
      outValid    <= 1'b0;
      outData     <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      creditCount <= cnt_d;
      lowCredits  <= low_d;
      creditError <= err_d;
      outValid    <= send;
      if (send) outData <= inData;
    end
  end

endmodule

// File: tb/tb_oclib_credit_tx.sv
// Directed bench for oclib_credit_tx with hand-computed expectations.
module tb_oclib_credit_tx;

  logic        clock;
  logic        resetN;
  logic [31:0] inData;
  logic        inValid;
  logic        inReady;
  logic [31:0] outData;
  logic        outValid;
  logic [1:0]  creditIn;
  logic [5:0]  creditCount;
  logic        lowCredits;
  logic        creditError;

  int total;
  int bad;

  oclib_credit_tx #(
    .Width(32), .Credits(32), .CreditInW(2),
    .LowCredits(4), .InitDelay(4)
  ) dut (
    .clock(clock),
    .resetN(resetN),
    .inData(inData),
    .inValid(inValid),
    .inReady(inReady),
    .outData(outData),
    .outValid(outValid),
    .creditIn(creditIn),
    .creditCount(creditCount),
    .lowCredits(lowCredits),
    .creditError(creditError)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic run_init();
    inValid  = 1'b0;
    creditIn = 2'd0;
    resetN   = 1'b0;
    step();
    chk("rst_cnt", creditCount, 0);
    chk("rst_vld", outValid, 0);
    chk("rst_dat", outData, 0);
    chk("rst_low", lowCredits, 1);
    chk("rst_err", creditError, 0);
    chk("rst_rdy", inReady, 0);
    resetN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("init_rdy", inReady, 0);
      step();
    end
    chk("run_rdy", inReady, 1);
    chk("run_cnt", creditCount, 32);
    chk("run_low", lowCredits, 0);
    chk("run_vld", outValid, 0);
    chk("run_err", creditError, 0);
  endtask

  initial begin
    int          exp_cnt;
    int          beats;
    logic        exp_send;
    logic [31:0] prev;
    logic [31:0] last;
    total    = 0;
    bad      = 0;
    resetN   = 1'b0;
    inData   = '0;
    inValid  = 1'b0;
    creditIn = 2'd0;

    // 1: reset and INIT delay
    run_init();

    // 2: drain all 32 credits with inValid held
    exp_cnt = 32;
    beats   = 0;
    last    = '0;
    inValid = 1'b1;
    for (int i = 0; i < 36; i++) begin
      inData   = 32'hA000_0000 + 32'(i);
      exp_send = (exp_cnt != 0);
      prev     = inData;
      chk("t2_rdy", inReady, exp_send);
      step();
      chk("t2_vld", outValid, exp_send);
      if (exp_send) begin
        beats++;
        exp_cnt--;
        last = prev;
      end
      chk("t2_dat", outData, last);
      chk("t2_cnt", creditCount, exp_cnt);
      chk("t2_low", lowCredits, exp_cnt <= 4);
    end
    chk("t2_beats", beats, 32);
    chk("t2_rdy0", inReady, 0);

    // 3: single credit at zero
    creditIn = 2'd1;
    chk("t3_rdy_pre", inReady, 0);
    step();
    creditIn = 2'd0;
    inData   = 32'h5555_AAAA;
    chk("t3_rdy", inReady, 1);
    chk("t3_cnt1", creditCount, 1);
    chk("t3_vld0", outValid, 0);
    step();
    chk("t3_vld1", outValid, 1);
    chk("t3_dat", outData, 32'h5555_AAAA);
    chk("t3_cnt0", creditCount, 0);
    chk("t3_rdy0", inReady, 0);
    step();
    chk("t3_vld2", outValid, 0);

    // 4: steady state at 3 credits, send and return each cycle
    inValid  = 1'b0;
    creditIn = 2'd3;
    step();
    chk("t4_cnt", creditCount, 3);
    inValid  = 1'b1;
    creditIn = 2'd1;
    for (int i = 0; i < 6; i++) begin
      inData = 32'hC0DE_0000 + 32'(i);
      prev   = inData;
      step();
      chk("t4_vld", outValid, 1);
      chk("t4_dat", outData, prev);
      chk("t4_cnt", creditCount, 3);
    end
    inValid  = 1'b0;
    creditIn = 2'd0;
    step();
    chk("t4_vld0", outValid, 0);
    chk("t4_hold", outData, prev);
    chk("t4_cnt3", creditCount, 3);

    // 5: overflow saturates and latches the error
    creditIn = 2'd3;
    for (int i = 0; i < 9; i++) step();
    creditIn = 2'd1;
    step();
    chk("t5_cnt31", creditCount, 31);
    chk("t5_err0", creditError, 0);
    chk("t5_low0", lowCredits, 0);
    creditIn = 2'd3;
    step();
    chk("t5_sat", creditCount, 32);
    chk("t5_err1", creditError, 1);
    creditIn = 2'd0;
    inValid  = 1'b1;
    inData   = 32'h1234_5678;
    step();
    chk("t5_cnt", creditCount, 31);
    chk("t5_sticky", creditError, 1);
    chk("t5_vld", outValid, 1);

    // 6: async reset mid-burst, then INIT repeats
    step();
    chk("t6_vld", outValid, 1);
    resetN = 1'b0;
    #1;
    chk("t6_vld0", outValid, 0);
    chk("t6_cnt0", creditCount, 0);
    chk("t6_rdy0", inReady, 0);
    chk("t6_err0", creditError, 0);
    run_init();

    // 7: credit arriving during INIT is an error
    resetN = 1'b0;
    step();
    resetN   = 1'b1;
    creditIn = 2'd1;
    step();
    creditIn = 2'd0;
    chk("t7_err", creditError, 1);
    chk("t7_cnt", creditCount, 0);
    step();
    step();
    step();
    chk("t7_rdy", inReady, 1);
    chk("t7_run", creditCount, 32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
